lsb_issue_queue: RTL and testbench

Parametrised, age-ordered reservation station that feeds the LoadStoreBuffer. It holds dispatched load/store micro-ops until both operands (base and store data) are resolved, snoops a configurable number of result broadcast ports, and issues the oldest ready entry with its effective address (base + imm) over a valid/ready handshake. It replaces the fixed 8-entry, lowest-index-first load/store RS. It adds explicit operand-valid bits (ROB id 0 is a legal tag), same-cycle dispatch bypass, back-pressure, and an optional load-behind-store ordering barrier.

---
 rtl/lsb_issue_queue_if.sv | 44 ++++
 rtl/lsb_issue_queue.sv | 178 +++++++++++++++++
 tb/tb_lsb_issue_queue.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lsb_issue_queue_if.sv
// Dispatch, wakeup-broadcast and issue bundle between the load/store issue queue and its neighbours.
// The master side is the dispatcher, broadcaster and LoadStoreBuffer; the slave side is the queue.
interface lsb_issue_queue_if #(
    parameter int ROB_W = 5,
    parameter int XLEN  = 32,
    parameter int NWB   = 5
);
    logic                   clear;
    logic                   disp_valid;
    logic [6:0]             disp_type;
    logic                   disp_is_store;
    logic [ROB_W-1:0]       disp_rob_id;
    logic [XLEN-1:0]        disp_v1;
    logic [XLEN-1:0]        disp_sv;
    logic [XLEN-1:0]        disp_imm;
    logic                   disp_has_dep1;
    logic                   disp_has_dep2;
    logic [ROB_W-1:0]       disp_dep1;
    logic [ROB_W-1:0]       disp_dep2;
    logic                   rs_full;
    logic [NWB-1:0]         wb_valid;
    logic [NWB*ROB_W-1:0]   wb_rob_id;
    logic [NWB*XLEN-1:0]    wb_value;
    logic                   iss_valid;
    logic                   iss_ready;
    logic [ROB_W-1:0]       iss_rob_id;
    logic [6:0]             iss_type;
    logic [XLEN-1:0]        iss_st_value;
    logic [XLEN-1:0]        iss_addr;

    modport master (
        output clear, disp_valid, disp_type, disp_is_store, disp_rob_id, disp_v1, disp_sv,
               disp_imm, disp_has_dep1, disp_has_dep2, disp_dep1, disp_dep2,
               wb_valid, wb_rob_id, wb_value, iss_ready,
        input  rs_full, iss_valid, iss_rob_id, iss_type, iss_st_value, iss_addr
    );

    modport slave (
        input  clear, disp_valid, disp_type, disp_is_store, disp_rob_id, disp_v1, disp_sv,
               disp_imm, disp_has_dep1, disp_has_dep2, disp_dep1, disp_dep2,
               wb_valid, wb_rob_id, wb_value, iss_ready,
        output rs_full, iss_valid, iss_rob_id, iss_type, iss_st_value, iss_addr
    );
endinterface

// File: rtl/lsb_issue_queue.sv
// Age-ordered load/store reservation station: snoops result broadcasts and
// issues the oldest ready entry with its effective address to the LoadStoreBuffer.
module lsb_issue_queue #(
    parameter int DEPTH         = 8,
    parameter int ROB_W         = 5,
    parameter int XLEN          = 32,
    parameter int NWB           = 5,
    parameter int STORE_BARRIER = 0
) (
    input logic              clk_in,
    input logic              rst_in,
    input logic              rdy_in,
    lsb_issue_queue_if.slave io
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] busy_q, busy_d, is_store_q, is_store_d;
    logic [DEPTH-1:0] rdy1_q, rdy1_d, rdy2_q, rdy2_d;
    logic [6:0]       type_q [DEPTH], type_d [DEPTH];
    logic [ROB_W-1:0] rob_q  [DEPTH], rob_d  [DEPTH];
    logic [ROB_W-1:0] dep1_q [DEPTH], dep1_d [DEPTH];
    logic [ROB_W-1:0] dep2_q [DEPTH], dep2_d [DEPTH];
    logic [XLEN-1:0]  v1_q   [DEPTH], v1_d   [DEPTH];
    logic [XLEN-1:0]  sv_q   [DEPTH], sv_d   [DEPTH];
    logic [XLEN-1:0]  imm_q  [DEPTH], imm_d  [DEPTH];
    logic [DEPTH-1:0] older_q [DEPTH], older_d [DEPTH];  // older[i][j]: entry i predates entry j
    logic [CW-1:0]    count_q, count_d;

    logic [DEPTH-1:0] elig, sel, store_older;
    logic [IW-1:0]    sel_idx, free_idx;
    logic             iss_valid, rs_full, disp_go, fire;
    logic [XLEN-1:0]  iss_v1, iss_imm;

    always_comb begin
        store_older = '0;
        elig        = '0;
        sel         = '0;
        sel_idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < DEPTH; k++)
                if (busy_q[k] && is_store_q[k] && older_q[k][i]) store_older[i] = 1'b1;
            elig[i] = busy_q[i] && rdy1_q[i] && rdy2_q[i] &&
                      !(STORE_BARRIER != 0 && !is_store_q[i] && store_older[i]);
        end
        for (int i = 0; i < DEPTH; i++) begin
            sel[i] = elig[i];
            for (int k = 0; k < DEPTH; k++)
                if (elig[k] && older_q[k][i]) sel[i] = 1'b0;
            if (sel[i]) sel_idx = IW'(i);
        end
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!busy_q[i]) free_idx = IW'(i);
    end

    assign iss_valid = |elig;
    assign rs_full   = (count_q == CW'(DEPTH));
    assign disp_go   = rdy_in && io.disp_valid && !rs_full;
    assign fire      = rdy_in && iss_valid && io.iss_ready;

    always_comb begin
        io.iss_rob_id   = '0;
        io.iss_type     = '0;
        io.iss_st_value = '0;
        iss_v1          = '0;
        iss_imm         = '0;
        if (iss_valid) begin
            io.iss_rob_id   = rob_q[sel_idx];
            io.iss_type     = type_q[sel_idx];
            io.iss_st_value = sv_q[sel_idx];
            iss_v1          = v1_q[sel_idx];
            iss_imm         = imm_q[sel_idx];
        end
    end

    assign io.iss_addr  = iss_v1 + iss_imm;
    assign io.iss_valid = iss_valid;
    assign io.rs_full   = rs_full;

    always_comb begin
        busy_d     = busy_q;
        is_store_d = is_store_q;
        rdy1_d     = rdy1_q;
        rdy2_d     = rdy2_q;
        type_d     = type_q;
        rob_d      = rob_q;
        dep1_d     = dep1_q;
        dep2_d     = dep2_q;
        v1_d       = v1_q;
        sv_d       = sv_q;
        imm_d      = imm_q;
        older_d    = older_q;
        count_d    = count_q;

        // Ascending port scan so the highest-numbered matching port wins.
        if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int p = 0; p < NWB; p++) begin
                    if (busy_q[i] && io.wb_valid[p]) begin
                        if (!rdy1_q[i] && io.wb_rob_id[p*ROB_W +: ROB_W] == dep1_q[i]) begin
                            rdy1_d[i] = 1'b1;
                            v1_d[i]   = io.wb_value[p*XLEN +: XLEN];
                        end
                        if (!rdy2_q[i] && io.wb_rob_id[p*ROB_W +: ROB_W] == dep2_q[i]) begin
                            rdy2_d[i] = 1'b1;
                            sv_d[i]   = io.wb_value[p*XLEN +: XLEN];
                        end
                    end
                end
            end
        end

        if (disp_go) begin
            busy_d[free_idx]     = 1'b1;
            is_store_d[free_idx] = io.disp_is_store;
            type_d[free_idx]     = io.disp_type;
            rob_d[free_idx]      = io.disp_rob_id;
            dep1_d[free_idx]     = io.disp_dep1;
            dep2_d[free_idx]     = io.disp_dep2;
            imm_d[free_idx]      = io.disp_imm;
            rdy1_d[free_idx]     = !io.disp_has_dep1;
            rdy2_d[free_idx]     = !io.disp_has_dep2;
            v1_d[free_idx]       = io.disp_v1;
            sv_d[free_idx]       = io.disp_sv;
            for (int p = 0; p < NWB; p++) begin
                if (io.wb_valid[p] && io.disp_has_dep1 &&
                    io.wb_rob_id[p*ROB_W +: ROB_W] == io.disp_dep1) begin
                    rdy1_d[free_idx] = 1'b1;
                    v1_d[free_idx]   = io.wb_value[p*XLEN +: XLEN];
                end
                if (io.wb_valid[p] && io.disp_has_dep2 &&
                    io.wb_rob_id[p*ROB_W +: ROB_W] == io.disp_dep2) begin
                    rdy2_d[free_idx] = 1'b1;
                    sv_d[free_idx]   = io.wb_value[p*XLEN +: XLEN];
                end
            end
            for (int k = 0; k < DEPTH; k++) older_d[k][free_idx] = busy_q[k];
            older_d[free_idx] = '0;
        end

        if (fire) begin
            busy_d[sel_idx]  = 1'b0;
            older_d[sel_idx] = '0;
            for (int k = 0; k < DEPTH; k++) older_d[k][sel_idx] = 1'b0;
        end

        case ({disp_go, fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || io.clear) begin
            busy_q  <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
        end else begin
            busy_q  <= busy_d;
            rdy1_q  <= rdy1_d;
            rdy2_q  <= rdy2_d;
            count_q <= count_d;
            older_q <= older_d;
        end
        is_store_q <= is_store_d;
        type_q     <= type_d;
        rob_q      <= rob_d;
        dep1_q     <= dep1_d;
        dep2_q     <= dep2_d;
        v1_q       <= v1_d;
        sv_q       <= sv_d;
        imm_q      <= imm_d;
    end
endmodule

// File: tb/tb_lsb_issue_queue.sv
// Directed bench for lsb_issue_queue (DEPTH=8, STORE_BARRIER=1); issue traffic is
// checked against a scoreboard of hand-computed expected issues.
module tb_lsb_issue_queue;
    logic clk = 1'b0;
    logic rst, rdy;
    int   n_cmp = 0;
    int   n_err = 0;

    typedef struct {
        logic [4:0]  rob;
        logic [6:0]  typ;
        logic [31:0] addr;
        logic [31:0] st;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    lsb_issue_queue_if #(.ROB_W(5), .XLEN(32), .NWB(5)) bus ();

    lsb_issue_queue #(
        .DEPTH(8), .ROB_W(5), .XLEN(32), .NWB(5), .STORE_BARRIER(1)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .io     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.disp_valid = 1'b0;
        bus.wb_valid   = '0;
    endtask

    task automatic disp(input int st, input int rob, input int typ, input int v1, input int sv,
                        input int imm, input int h1, input int d1, input int h2, input int d2);
        bus.disp_valid    = 1'b1;
        bus.disp_is_store = (st != 0);
        bus.disp_rob_id   = 5'(rob);
        bus.disp_type     = 7'(typ);
        bus.disp_v1       = 32'(v1);
        bus.disp_sv       = 32'(sv);
        bus.disp_imm      = 32'(imm);
        bus.disp_has_dep1 = (h1 != 0);
        bus.disp_dep1     = 5'(d1);
        bus.disp_has_dep2 = (h2 != 0);
        bus.disp_dep2     = 5'(d2);
    endtask

    task automatic wb(input int p, input int tag, input int val);
        bus.wb_valid[p]           = 1'b1;
        bus.wb_rob_id[p*5 +: 5]   = 5'(tag);
        bus.wb_value[p*32 +: 32]  = 32'(val);
    endtask

    task automatic push(input int rob, input int typ, input int addr, input int st);
        exp_t x;
        x.rob  = 5'(rob);
        x.typ  = 7'(typ);
        x.addr = 32'(addr);
        x.st   = 32'(st);
        sb.push_back(x);
    endtask

    // Monitor: every accepted issue must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst && rdy && bus.iss_valid && bus.iss_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_issue: got rob %0d, required no issue", bus.iss_rob_id);
            end else begin
                e = sb.pop_front();
                check("iss_rob_id",   32'(bus.iss_rob_id), 32'(e.rob));
                check("iss_type",     32'(bus.iss_type),   32'(e.typ));
                check("iss_addr",     bus.iss_addr,        e.addr);
                check("iss_st_value", bus.iss_st_value,    e.st);
            end
        end
    end

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        bus.clear         = 1'b0;
        bus.iss_ready     = 1'b0;
        bus.wb_rob_id     = '0;
        bus.wb_value      = '0;
        disp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_rs_full",   32'(bus.rs_full),    0);
        check("reset_iss_valid", 32'(bus.iss_valid),  0);
        check("reset_iss_rob",   32'(bus.iss_rob_id), 0);
        check("reset_iss_addr",  bus.iss_addr,        0);

        // Single ready load: issues the cycle after dispatch.
        bus.iss_ready = 1'b1;
        disp(0, 3, 'h03, 'h100, 0, 'h24, 0, 0, 0, 0);
        push(3, 'h03, 'h124, 0);
        tick();
        idle();
        check("t1_valid_next_cycle", 32'(bus.iss_valid), 1);
        check("t1_addr",             bus.iss_addr,       'h124);
        tick();
        check("t1_drained",          32'(bus.iss_valid), 0);
        check("t1_not_full",         32'(bus.rs_full),   0);

        // Tag 0 wakeup on port 4; younger ready entry goes first.
        disp(0, 1, 'h11, 'hdead, 0, 'h10, 1, 0, 0, 0);
        tick();
        disp(0, 2, 'h12, 'h200, 0, 4, 0, 0, 0, 0);
        tick();
        idle();
        wb(4, 0, 'h40);
        push(2, 'h12, 'h204, 0);
        push(1, 'h11, 'h50, 0);
        check("t2_young_first", 32'(bus.iss_rob_id), 2);
        tick();
        idle();
        check("t2_woken_rob",  32'(bus.iss_rob_id), 1);
        check("t2_woken_addr", bus.iss_addr,        'h50);
        tick();
        check("t2_drained",    32'(bus.iss_valid),  0);

        // Fill, hold oldest under back-pressure, then dispatch+fire while full.
        bus.iss_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            disp(0, 8 + i, 'h20 + i, 'h1000, i, 4 * i, 0, 0, 0, 0);
            tick();
        end
        idle();
        check("t3_full", 32'(bus.rs_full), 1);
        for (int r = 0; r < 5; r++) begin
            check("t3_hold_valid", 32'(bus.iss_valid),  1);
            check("t3_hold_rob",   32'(bus.iss_rob_id), 8);
            tick();
        end
        push(8, 'h20, 'h1000, 0);
        disp(0, 20, 'h7f, 'h9999, 0, 0, 0, 0, 0, 0);
        bus.iss_ready = 1'b1;
        tick();
        idle();
        bus.iss_ready = 1'b0;
        check("t3_count7_not_full", 32'(bus.rs_full),    0);
        check("t3_next_oldest",     32'(bus.iss_rob_id), 9);
        disp(0, 21, 'h30, 'h2000, 5, 8, 0, 0, 0, 0);
        tick();
        idle();
        check("t3_refull", 32'(bus.rs_full), 1);
        for (int i = 1; i < 8; i++) push(8 + i, 'h20 + i, 'h1000 + 4 * i, i);
        push(21, 'h30, 'h2008, 5);
        bus.iss_ready = 1'b1;
        repeat (8) tick();
        bus.iss_ready = 1'b0;
        check("t3_drained",  32'(bus.iss_valid), 0);
        check("t3_not_full", 32'(bus.rs_full),   0);

        // Store barrier: ready load waits behind an older unresolved store.
        bus.iss_ready = 1'b1;
        disp(1, 5, 'h40, 'h300, 0, 8, 0, 0, 1, 7);
        tick();
        disp(0, 6, 'h41, 'h400, 'h55, 0, 0, 0, 0, 0);
        tick();
        idle();
        check("t4_blocked_a", 32'(bus.iss_valid), 0);
        tick();
        check("t4_blocked_b", 32'(bus.iss_valid), 0);
        wb(1, 7, 'hab);
        push(5, 'h40, 'h308, 'hab);
        push(6, 'h41, 'h400, 'h55);
        tick();
        idle();
        check("t4_store_first", 32'(bus.iss_rob_id), 5);
        tick();
        check("t4_load_next",   32'(bus.iss_rob_id), 6);
        tick();
        check("t4_drained",     32'(bus.iss_valid),  0);

        // Dispatch bypass from port 0 in the dispatch cycle.
        disp(0, 10, 'h50, 0, 0, 'h30, 1, 9, 0, 0);
        wb(0, 9, 'h8);
        push(10, 'h50, 'h38, 0);
        tick();
        idle();
        check("t5_valid", 32'(bus.iss_valid), 1);
        check("t5_addr",  bus.iss_addr,       'h38);
        tick();
        check("t5_drained", 32'(bus.iss_valid), 0);

        // Flush with busy entries, then a frozen cycle must not record a wakeup.
        bus.iss_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            disp(0, i, 'h60, 'h100 * i, 0, 0, 0, 0, 0, 0);
            tick();
        end
        idle();
        check("t6_busy_before_clear", 32'(bus.iss_valid), 1);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("t6_clear_full",  32'(bus.rs_full),    0);
        check("t6_clear_valid", 32'(bus.iss_valid),  0);
        check("t6_clear_rob",   32'(bus.iss_rob_id), 0);
        check("t6_clear_addr",  bus.iss_addr,        0);
        disp(0, 12, 'h61, 0, 0, 4, 1, 17, 0, 0);
        tick();
        idle();
        rdy = 1'b0;
        bus.iss_ready = 1'b1;
        wb(2, 17, 'h70);
        tick();
        rdy = 1'b1;
        idle();
        check("t6_frozen_no_wake", 32'(bus.iss_valid), 0);
        tick();
        check("t6_still_waiting",  32'(bus.iss_valid), 0);
        wb(2, 17, 'h70);
        push(12, 'h61, 'h74, 0);
        tick();
        idle();
        check("t6_woken_valid", 32'(bus.iss_valid), 1);
        check("t6_woken_addr",  bus.iss_addr,       'h74);
        tick();
        check("t6_drained",     32'(bus.iss_valid), 0);

        tick();
        check("scoreboard_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
